fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Next-generation IF stage: decouples PC generation from a latency-variable instruction memory
//  via a DEPTH-entry prefetch queue. Issues in-order fetch requests ahead of decode, pairs each
//  response with its PC, presents one instruction per cycle to ID, and flushes on EX redirect
//  (PCSrcE), discarding stale in-flight responses. Replaces combinational-imem fetch.
// PARAMETERS
//  XLEN      riscv_pkg::XLEN  address/PC width
//  DEPTH     4                queue slots = max outstanding+buffered; power of 2, >=2
//  RESET_PC  '0               PC of first fetch after reset
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  PCSrcE         in   1     redirect: flush queue, refetch from PCTargetE
//  PCTargetE      in   XLEN  redirect target; bits [1:0] ignored (forced 0)
//  StallF         in   1     ID not ready; head held
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     memory accepts request
//  imem_req_addr  out  XLEN  word-aligned fetch address
//  imem_rsp_valid in   1     response data valid; in request order, no backpressure
//  imem_rsp_data  in   32    instruction word
//  FetchValidF    out  1     InstrF/PCF/PCPlus4F valid this cycle
//  InstrF         out  32    head instruction
//  PCF            out  XLEN  head PC
//  PCPlus4F       out  XLEN  PCF+4 (mod 2^XLEN)
// BEHAVIOUR
//  - Reset: reqPC=RESET_PC, alloc/fill/head ptrs=0, drop_cnt=0, all slots empty; outputs
//    imem_req_valid=0, FetchValidF=0, InstrF=0, PCF=0, PCPlus4F=4. Memory shares rst; no response
//    is returned for a request issued before reset.
//  - Slot ring, three ptrs (clog2(DEPTH)+1 bits, MSB = wrap): alloc (tail), fill, head.
//    used = alloc-head. Credit: imem_req_valid = (used + drop_cnt < DEPTH) & !PCSrcE.
//  - Request handshake (valid&ready): slot[alloc].pc=reqPC, filled=0; alloc++; reqPC+=4.
//  - Response with drop_cnt>0: discarded, drop_cnt--. Otherwise slot[fill].instr=data, filled=1,
//    fill++. Responses never exceed credits: no overflow possible.
//  - Output (combinational from head): FetchValidF = slot[head].filled & (used!=0) & !PCSrcE.
//    Dequeue when FetchValidF & !StallF: head++. Min latency request->FetchValidF = mem latency
//    + 1 cycle (registered fill).
//  - Redirect (PCSrcE=1), same edge, overriding all else: drop_cnt <= drop_cnt + (alloc-fill)
//    - (response accepted this cycle ? 1 : 0, counted as dropped); all ptrs <= alloc (empty);
//    reqPC <= {PCTargetE[XLEN-1:2],2'b00}; no request issued, no dequeue this cycle.
//  - Full (used+drop_cnt==DEPTH): req_valid=0; resumes cycle after a dequeue or drop.
//  - Empty/unfilled head: FetchValidF=0, InstrF/PCF hold last head slot contents.
//  - StallF with full queue: all state held; responses still land (credits guarantee space).
//  - reqPC wraps modulo 2^XLEN silently.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds out ports perf_req_cnt[31:0] (accepted requests),
//   perf_drop_cnt[31:0] (discarded responses), perf_starve_cnt[31:0] (cycles !FetchValidF & !rst
//   & !PCSrcE); all 0 on rst, wrap at 2^32. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  riscv_pkg: fetch_slot_t struct {pc[XLEN], instr[32], filled}; NOP_INSTR=32'h00000013
//  (InstrF reset/flush value alternative not used: InstrF resets to 0).
//  Sub-module fetch_slot_ring: storage + alloc/fill/head ptrs + used count; top holds reqPC,
//  drop_cnt, credit logic, perf counters. PC+4 via existing adder.
// TESTING
//  1 Reset, 1-cycle mem, StallF=0 -> req addrs 0,4,8..; FetchValidF first high 2 cycles after
//    rst drop; PCF 0,4,8 one per cycle.
//  2 StallF=1 continuously, DEPTH=4 -> exactly 4 requests accepted, then req_valid=0; release
//    -> PCF 0,4,8,C back-to-back, next request issued cycle after first dequeue.
//  3 3-cycle mem, 3 in flight (0,4,8), PCSrcE=1 PCTargetE=0x100 -> next 3 responses discarded,
//    first FetchValidF shows PCF=0x100, no 0/4/8 visible.
//  4 PCSrcE coincident with request handshake and response -> both squashed/dropped, drop_cnt
//    accounting exact; PCTargetE=0x203 fetches 0x200.
//  5 imem_req_ready random 50%, random StallF, random redirects, 10k cycles -> scoreboard:
//    delivered PC stream = sequential from last target, instr matches memory model, no loss.
//  6 rst asserted mid-stream with queue full -> next cycle all outputs at reset values, first
//    fetch from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Provides the PC/address width and the prefetch slot record used by the slot ring.
// Types only: no logic, no latency, no flow control.
package riscv_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch queue entry: the PC it was fetched from, the returned word,
  // and whether the memory response has landed yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_ring.sv
// Prefetch slot ring: DEPTH slots with alloc (tail), fill and head pointers.
// Latency: alloc/fill/dequeue take effect on the next clock edge; head fields are combinational.
// Backpressure: none internally; the caller only allocates while credits remain.
// Ports: clk/rst; i_flush empties the ring; i_alloc + i_alloc_pc reserve the tail slot;
//   i_fill + i_fill_instr complete the oldest unfilled slot; i_deq pops the head;
//   o_head_* expose the head slot; o_used = alloc-head; o_inflight = alloc-fill.
module fetch_slot_ring
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [31:0]     i_fill_instr,
  input  logic            i_deq,
  output logic [XLEN-1:0] o_head_pc,
  output logic [31:0]     o_head_instr,
  output logic            o_head_filled,
  output logic [PW-1:0]   o_used,
  output logic [PW-1:0]   o_inflight
);

  localparam int IW = PW - 1;

  fetch_slot_t r_slots [DEPTH];
  // Pointers carry one extra MSB as a wrap bit so full and empty differ.
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_head  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
    end else if (i_flush) begin
      // Everything allocated so far is abandoned; slot contents are left as-is
      // and are re-initialised on their next allocation.
      r_fill <= r_alloc;
      r_head <= r_alloc;
    end else begin
      if (i_alloc) begin
        r_slots[r_alloc[IW-1:0]].pc     <= i_alloc_pc;
        r_slots[r_alloc[IW-1:0]].filled <= 1'b0;
        r_alloc <= r_alloc + PW'(1);
      end
      // fill never equals alloc here: a response implies an outstanding slot.
      if (i_fill) begin
        r_slots[r_fill[IW-1:0]].instr  <= i_fill_instr;
        r_slots[r_fill[IW-1:0]].filled <= 1'b1;
        r_fill <= r_fill + PW'(1);
      end
      if (i_deq) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  assign o_head_pc     = r_slots[r_head[IW-1:0]].pc;
  assign o_head_instr  = r_slots[r_head[IW-1:0]].instr;
  assign o_head_filled = r_slots[r_head[IW-1:0]].filled;
  assign o_used        = r_alloc - r_head;
  assign o_inflight    = r_alloc - r_fill;

endmodule

// File: rtl/fetch_prefetch.sv
// IF stage with a DEPTH-entry prefetch queue between PC generation and instruction memory.
// Latency: request to FetchValidF is memory latency + 1 cycle (responses are registered into the ring).
// Backpressure: requests are credit-limited (queued + to-be-dropped < DEPTH); StallF holds the head.
// Ports: clk, rst (sync, active-high); PCSrcE/PCTargetE redirect; StallF from ID;
//   imem_req_* valid/ready request channel; imem_rsp_* in-order response (no backpressure);
//   FetchValidF/InstrF/PCF/PCPlus4F to ID.
// Optional FETCH_PERF_EN macro: adds perf_req_cnt, perf_drop_cnt, perf_starve_cnt outputs.
module fetch_prefetch #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            FetchValidF,
  output logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_req_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_starve_cnt
`endif
);

  import riscv_pkg::*;

  localparam int          PW      = $clog2(DEPTH) + 1;
  localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);

  logic [XLEN-1:0] r_req_pc;
  // Responses still owed by memory for requests abandoned by a redirect.
  logic [PW-1:0]   r_drop_cnt;

  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_inflight;
  logic [XLEN-1:0] w_head_pc;
  logic [31:0]     w_head_instr;
  logic            w_head_filled;
  logic [PW:0]     w_occ;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_fill;
  logic            w_deq;

  // Dropped-but-pending responses still consume credit so they never overrun the ring.
  assign w_occ          = {1'b0, w_used} + {1'b0, r_drop_cnt};
  assign imem_req_valid = !rst && (w_occ < L_DEPTH) && !PCSrcE;
  assign imem_req_addr  = r_req_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response arriving on a redirect cycle belongs to the flushed stream.
  assign w_rsp_drop = imem_rsp_valid && ((r_drop_cnt != '0) || PCSrcE);
  assign w_rsp_fill = imem_rsp_valid && !w_rsp_drop;

  assign FetchValidF = !rst && w_head_filled && (w_used != '0) && !PCSrcE;
  assign w_deq       = FetchValidF && !StallF;
  assign InstrF      = w_head_instr;
  assign PCF         = w_head_pc;
  assign PCPlus4F    = w_head_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc   <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (PCSrcE) begin
      // Everything still outstanding becomes droppable, minus the response
      // consumed this very cycle.
      r_drop_cnt <= r_drop_cnt + w_inflight - {{(PW-1){1'b0}}, imem_rsp_valid};
      r_req_pc   <= PCTargetE & ~XLEN'(3);
    end else begin
      if (w_req_fire) begin
        r_req_pc <= r_req_pc + XLEN'(4);
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - PW'(1);
      end
    end
  end

  fetch_slot_ring #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ring (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (PCSrcE),
    .i_alloc       (w_req_fire),
    .i_alloc_pc    (r_req_pc),
    .i_fill        (w_rsp_fill),
    .i_fill_instr  (imem_rsp_data),
    .i_deq         (w_deq),
    .o_head_pc     (w_head_pc),
    .o_head_instr  (w_head_instr),
    .o_head_filled (w_head_filled),
    .o_used        (w_used),
    .o_inflight    (w_inflight)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_req;
  logic [31:0] r_perf_drop;
  logic [31:0] r_perf_starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_req    <= '0;
      r_perf_drop   <= '0;
      r_perf_starve <= '0;
    end else begin
      if (w_req_fire)                 r_perf_req    <= r_perf_req + 32'd1;
      if (w_rsp_drop)                 r_perf_drop   <= r_perf_drop + 32'd1;
      if (!FetchValidF && !PCSrcE)    r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_req_cnt    = r_perf_req;
  assign perf_drop_cnt   = r_perf_drop;
  assign perf_starve_cnt = r_perf_starve;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: in-order memory model with variable latency,
// scoreboard of expected (PC, instr) pushed at request handshake and popped at dequeue.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallF = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        FetchValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_req_cnt, perf_drop_cnt, perf_starve_cnt;
`endif

  fetch_prefetch #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallF         (StallF),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .FetchValidF    (FetchValidF),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F)
`ifdef FETCH_PERF_EN
    ,
    .perf_req_cnt   (perf_req_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;
  typedef struct { logic [31:0] data; int due; } pend_t;

  sb_t   sb[$];
  pend_t pend[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  logic [31:0] exp_pc = '0;

  int nfire, ndeq;
  int first_fv_cyc, first_deq_cyc, first_fire_cyc;
  logic [31:0] first_deq_pc, first_fire_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic arm();
    nfire = 0; ndeq = 0;
    first_fv_cyc = -1; first_deq_cyc = -1; first_fire_cyc = -1;
    first_deq_pc = 32'hFFFF_FFFF; first_fire_addr = 32'hFFFF_FFFF;
  endtask

  // Evaluate the cycle's handshakes at the falling edge, before they commit.
  task automatic monitor();
    sb_t   e;
    pend_t p;
    int    due;
    if (rst) begin
      pend.delete(); sb.delete(); exp_pc = '0; last_due = 0;
      return;
    end
    if (imem_rsp_valid && pend.size() > 0) pend.delete(0);
    if (FetchValidF && first_fv_cyc < 0) first_fv_cyc = cyc;
    if (PCSrcE) begin
      chk("redir_req_vld", {31'b0, imem_req_valid}, 32'd0);
      chk("redir_fetch_vld", {31'b0, FetchValidF}, 32'd0);
      sb.delete();
      exp_pc = PCTargetE & ~32'h3;
      return;
    end
    if (FetchValidF && !StallF) begin
      if (sb.size() == 0) begin
        chk("deq_unexpected", {31'b0, FetchValidF}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pcf", PCF, e.pc);
        chk("instrf", InstrF, e.instr);
        chk("pcplus4f", PCPlus4F, e.pc + 32'd4);
      end
      if (first_deq_cyc < 0) begin first_deq_cyc = cyc; first_deq_pc = PCF; end
      ndeq++;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due < last_due) due = last_due;
      last_due = due;
      p.data = memw(imem_req_addr); p.due = due;
      pend.push_back(p);
      e.pc = exp_pc; e.instr = memw(exp_pc);
      sb.push_back(e);
      exp_pc = exp_pc + 32'd4;
      if (first_fire_cyc < 0) begin first_fire_cyc = cyc; first_fire_addr = imem_req_addr; end
      nfire++;
    end
  endtask

  task automatic mem_drive();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = pend[0].data;
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_vld"}, {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_fetch_vld"}, {31'b0, FetchValidF}, 32'd0);
    chk({tag, "_instrf"}, InstrF, 32'd0);
    chk({tag, "_pcf"}, PCF, 32'd0);
    chk({tag, "_pcplus4f"}, PCPlus4F, 32'd4);
  endtask

  // Reset for two cycles, leave the bench at the first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; imem_req_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    arm();
  endtask

  int r0;

  initial begin
    // T1: reset values, first fetch timing, one instruction per cycle.
    rst = 1'b1;
    cycle();
    chk_reset_outputs("t1_rst");
    rst = 1'b0; arm(); r0 = cyc;
    repeat (8) cycle();
    chk("t1_first_valid_delay", 32'(first_fv_cyc - r0), 32'd2);
    chk("t1_deq_count", 32'(ndeq), 32'd6);
    chk("t1_first_pc", first_deq_pc, 32'h0);

    // T2: continuous stall fills the queue, then drain back-to-back.
    do_reset();
    StallF = 1'b1;
    repeat (10) cycle();
    chk("t2_req_count", 32'(nfire), 32'd4);
    chk("t2_full_req_vld", {31'b0, imem_req_valid}, 32'd0);
    StallF = 1'b0; arm();
    repeat (4) cycle();
    chk("t2_b2b_deq", 32'(ndeq), 32'd4);
    chk("t2_resume_delay", 32'(first_fire_cyc - first_deq_cyc), 32'd1);
    chk("t2_first_pc", first_deq_pc, 32'h0);
    repeat (6) cycle();

    // T3: 3-cycle memory, redirect with three requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) cycle();
    chk("t3_in_flight", 32'(nfire), 32'd3);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    cycle();
    PCSrcE = 1'b0; arm();
    repeat (15) cycle();
    chk("t3_first_pc", first_deq_pc, 32'h100);

    // T4: redirect on a cycle with a ready request and a landing response.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) cycle();
    chk("t4_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
    PCSrcE = 1'b1; PCTargetE = 32'h203;
    #1;
    chk("t4_req_squashed", {31'b0, imem_req_valid}, 32'd0);
    cycle();
    PCSrcE = 1'b0; arm();
    repeat (10) cycle();
    chk("t4_first_addr", first_fire_addr, 32'h200);
    chk("t4_first_pc", first_deq_pc, 32'h200);

    // T6: reset mid-stream with the queue full.
    do_reset();
    StallF = 1'b1;
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    chk_reset_outputs("t6_rst");
    rst = 1'b0; StallF = 1'b0; arm();
    repeat (6) cycle();
    chk("t6_first_addr", first_fire_addr, 32'h0);
    chk("t6_first_pc", first_deq_pc, 32'h0);

    // T5: random ready, stall, redirects and latency.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      imem_req_ready = ($urandom_range(1, 0) == 1);
      StallF = ($urandom_range(3, 0) == 0);
      PCSrcE = ($urandom_range(39, 0) == 0);
      if ($urandom_range(7, 0) == 0) PCTargetE = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           PCTargetE = $urandom;
      cycle();
    end
    PCSrcE = 1'b0; StallF = 1'b0; imem_req_ready = 1'b1;
    repeat (30) cycle();
    chk("t5_progress", {31'b0, (ndeq > 1000)}, 32'd1);
    chk("t5_drained", {31'b0, FetchValidF}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
